// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, programmable almost-full /
// almost-empty thresholds, push-while-full-with-pop and sticky error flags.
module sync_fifo_param #(
    parameter int fifo_width = 32,
    parameter int fifo_depth = 8,
    parameter int af_level   = fifo_depth - 2,
    parameter int ae_level   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [fifo_width-1:0]         data_in,
    input  logic                          clr_err,
    output logic [fifo_width-1:0]         data_out,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(fifo_depth):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int ADDR_W = $clog2(fifo_depth);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AF_LVL  = af_level[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_LVL  = ae_level[ADDR_W:0];

    logic [fifo_width-1:0] mem [fifo_depth];
    logic [ADDR_W:0]       wr_ptr;
    logic [ADDR_W:0]       rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Handshake: push/pop are requests sampled at posedge; push_ok/pop_ok say
    // whether the FIFO took them. A rejected request has no effect other than
    // raising its sticky error flag. A pop frees a slot in the same cycle, so
    // a full FIFO still accepts a push paired with a pop.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign pop_ok     = pop && !fifo_empty;
    assign push_ok    = push && (!fifo_full || pop_ok);

    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);
    assign data_out     = fifo_empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

    // Storage carries no reset; emptiness is defined purely by the pointers.
    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            // A new error in the same cycle as clr_err must not be lost.
            overflow  <= (push && !push_ok) || (overflow  && !clr_err);
            underflow <= (pop  && !pop_ok)  || (underflow && !clr_err);
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a queue-based reference model predicts
// data order, count, thresholds and sticky error flags on every cycle.
module tb_sync_fifo_param;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         push;
    logic         pop;
    logic [W-1:0] data_in;
    logic         clr_err;
    logic [W-1:0] data_out;
    logic         fifo_full;
    logic         fifo_empty;
    logic         almost_full;
    logic         almost_empty;
    logic [3:0]   count;
    logic         overflow;
    logic         underflow;

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_q[$];
    logic         m_ov;
    logic         m_uf;

    sync_fifo_param #(
        .fifo_width(W),
        .fifo_depth(D),
        .af_level  (AF),
        .ae_level  (AE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .clr_err     (clr_err),
        .data_out    (data_out),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int n;
        n = exp_q.size();
        check("count",        {28'd0, count},           W'(n));
        check("fifo_empty",   {31'd0, fifo_empty},      W'(n == 0));
        check("fifo_full",    {31'd0, fifo_full},       W'(n == D));
        check("almost_full",  {31'd0, almost_full},     W'(n >= AF));
        check("almost_empty", {31'd0, almost_empty},    W'(n <= AE));
        check("overflow",     {31'd0, overflow},        W'(m_ov));
        check("underflow",    {31'd0, underflow},       W'(m_uf));
        check("data_out",     data_out,                 (n == 0) ? '0 : exp_q[0]);
    endtask

    // One clock of stimulus; the model decides acceptance from its own fill level.
    task automatic step(input logic p, input logic po, input logic [W-1:0] d, input logic ce);
        logic         p_ok;
        logic         po_ok;
        logic [W-1:0] head;
        push    = p;
        pop     = po;
        data_in = d;
        clr_err = ce;
        po_ok   = po && (exp_q.size() != 0);
        p_ok    = p && ((exp_q.size() != D) || po_ok);
        if (po_ok) begin
            head = exp_q.pop_front();
            check("pop_data", data_out, head);
        end
        if (p_ok) exp_q.push_back(d);
        m_ov = (p && !p_ok) || (m_ov && !ce);
        m_uf = (po && !po_ok) || (m_uf && !ce);
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        push    = 1'b1;
        pop     = 1'b0;
        clr_err = 1'b0;
        data_in = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        m_ov = 1'b0;
        m_uf = 1'b0;
        check_state();
        reset = 1'b1;
        push  = 1'b0;
    endtask

    initial begin
        m_ov = 1'b0;
        m_uf = 1'b0;

        // Reset with push held: nothing may be written.
        do_reset();
        step(1'b0, 1'b0, '0, 1'b0);

        // Fill then drain in order.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'hA0 + W'(i), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0);

        // Pointer wrap: push 5 / pop 5, four rounds.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h100 + W'(r * 5 + i), 1'b0);
            for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0, 1'b0);
        end

        // Full with simultaneous push and pop.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h200 + W'(i), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 32'hBB, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0);

        // Error flags.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h300 + W'(i), 1'b0);
        step(1'b1, 1'b0, 32'hCC, 1'b0);
        step(1'b1, 1'b0, 32'hCD, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Empty with push and pop together.
        step(1'b1, 1'b1, 32'h55, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);

        // Random traffic, then a reset mid-operation.
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h400 + W'(i), 1'b0);
        do_reset();
        step(1'b0, 1'b1, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
